snake_hex_scoreboard: RTL and testbench

Avalon-MM slave that turns a binary score into a six-digit decimal readout on the HEX0–HEX5 seven-segment displays of the snake system. It replaces six independent per-digit PIO writes from the Nios firmware with a single score write. A sequential double-dabble converter produces the BCD digits, which are encoded to active-low segment patterns. Optional leading-zero blanking and whole-display blinking (game-over indication) are provided.

---
 rtl/snake_hex_scoreboard.sv | 194 +++++++++++++++++++
 tb/tb_snake_hex_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_hex_scoreboard.sv
// Avalon-MM score register -> six-digit decimal seven-segment readout (sequential double dabble).
// Optional blinking is compiled in with `define HEX_SCOREBOARD_BLINK_EN.
module snake_hex_scoreboard (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      r_state, w_nextState;
    logic [19:0] r_score, r_shift;
    logic [2:0]  r_ctrl, w_ctrlMask;
    logic        r_pending;
    logic [23:0] r_bcd, r_digits, w_bcdAdj, w_periodRd;
    logic [4:0]  r_count;
    logic [7:0]  r_hex [6];
    logic [7:0]  w_hexNext [6];
    logic        w_wr, w_scoreWr, w_ctrlWr, w_start, w_busy, w_phase;
    logic [19:0] w_satScore, w_startVal;

    function automatic logic [7:0] segCode(input logic [3:0] digit);
        case (digit)
            4'd0:    segCode = 8'hC0;
            4'd1:    segCode = 8'hF9;
            4'd2:    segCode = 8'hA4;
            4'd3:    segCode = 8'hB0;
            4'd4:    segCode = 8'h99;
            4'd5:    segCode = 8'h92;
            4'd6:    segCode = 8'h82;
            4'd7:    segCode = 8'hF8;
            4'd8:    segCode = 8'h80;
            4'd9:    segCode = 8'h90;
            default: segCode = 8'hFF;
        endcase
    endfunction

    assign w_wr       = chipselect & ~write_n;
    assign w_scoreWr  = w_wr & (address == 2'd0);
    assign w_ctrlWr   = w_wr & (address == 2'd1);
    assign w_satScore = (writedata > 32'd999999) ? 20'd999999 : writedata[19:0];
    assign w_busy     = (r_state != IDLE);
    // A fresh write in IDLE is newer than any pending value, so it wins.
    assign w_start    = (r_state == IDLE) & (w_scoreWr | r_pending);
    assign w_startVal = w_scoreWr ? w_satScore : r_score;

`ifdef HEX_SCOREBOARD_BLINK_EN
    logic [23:0] r_period, r_blinkCnt;
    logic        r_phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_period   <= 24'd0;
            r_blinkCnt <= 24'd0;
            r_phase    <= 1'b0;
        end else begin
            if (w_wr && address == 2'd3)
                r_period <= writedata[23:0];
            if (r_ctrl[2] && r_period != 24'd0) begin
                if (r_blinkCnt == r_period - 24'd1) begin
                    r_blinkCnt <= 24'd0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_blinkCnt <= r_blinkCnt + 24'd1;
                end
            end else begin
                r_blinkCnt <= 24'd0;
                r_phase    <= 1'b0;
            end
        end
    end

    assign w_phase    = r_phase;
    assign w_periodRd = r_period;
    assign w_ctrlMask = 3'b111;
`else
    assign w_phase    = 1'b0;
    assign w_periodRd = 24'd0;
    assign w_ctrlMask = 3'b011;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = SHIFT;
            SHIFT:   if (r_count == 5'd19) w_nextState = LOAD;
            LOAD:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_bcdAdj = r_bcd;
        for (int i = 0; i < 6; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_score   <= 20'd0;
            r_ctrl    <= 3'd0;
            r_pending <= 1'b0;
            r_shift   <= 20'd0;
            r_bcd     <= 24'd0;
            r_count   <= 5'd0;
            r_digits  <= 24'd0;
        end else begin
            if (w_scoreWr)
                r_score <= w_satScore;
            if (w_ctrlWr)
                r_ctrl <= writedata[2:0] & w_ctrlMask;
            if (w_start)
                r_pending <= 1'b0;
            else if (w_scoreWr && w_busy)
                r_pending <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift <= w_startVal;
                        r_bcd   <= 24'd0;
                        r_count <= 5'd0;
                    end
                end
                SHIFT: begin
                    r_bcd   <= {w_bcdAdj[22:0], r_shift[19]};
                    r_shift <= {r_shift[18:0], 1'b0};
                    r_count <= r_count + 5'd1;
                end
                LOAD:    r_digits <= r_bcd;
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: a digit blanks when it and every digit above it are zero.
    always_comb begin
        logic seenNz;
        seenNz = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            seenNz = seenNz | (r_digits[4*i +: 4] != 4'd0);
            if (!r_ctrl[0] || (r_ctrl[2] && w_phase) || (r_ctrl[1] && i != 0 && !seenNz))
                w_hexNext[i] = 8'hFF;
            else
                w_hexNext[i] = segCode(r_digits[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (!reset_n)
                r_hex[i] <= 8'hFF;
            else
                r_hex[i] <= w_hexNext[i];
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {12'd0, r_score};
            2'd1: readdata = {29'd0, r_ctrl};
            2'd2: readdata = {30'd0, r_pending, w_busy};
            2'd3: readdata = {8'd0, w_periodRd};
            default: readdata = 32'd0;
        endcase
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];

endmodule

// File: tb/tb_snake_hex_scoreboard.sv
// Directed self-checking bench for snake_hex_scoreboard; blink checks only when
// HEX_SCOREBOARD_BLINK_EN is defined, masking checks otherwise.
module tb_snake_hex_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int errors = 0;

    snake_hex_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Write lands on the next rising edge; returns 1 ns after it.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    function automatic logic [47:0] allHex();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          busyCycles;
        logic        saw7;
        logic        unsteady;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        waitEdges(3);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        checkOutput("reset_hex", allHex(), 48'hFFFF_FFFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            readReg(a[1:0], rd);
            checkOutput($sformatf("reset_rd%0d", a), {16'd0, rd}, 48'd0);
        end

        applyStimulus(2'd1, 32'd1);
        applyStimulus(2'd0, 32'd0);
        waitEdges(22);
        checkOutput("score0", allHex(), 48'hC0C0_C0C0_C0C0);

        // 123456: busy spans 21 samples, display flips exactly at E22
        applyStimulus(2'd0, 32'd123456);
        busyCycles = 0;
        for (int k = 0; k < 100; k++) begin
            readReg(2'd2, rd);
            if (!rd[0]) break;
            busyCycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("busy_len", 48'(busyCycles), 48'd21);
        checkOutput("pre_e22", {40'd0, hex0}, {40'd0, 8'hC0});
        waitEdges(1);
        checkOutput("score123456", allHex(), 48'hF9A4_B099_9282);
        readReg(2'd0, rd);
        checkOutput("rd_score", {16'd0, rd}, 48'h1E240);
        readReg(2'd2, rd);
        checkOutput("status_idle", {16'd0, rd}, 48'd0);

        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'd42);
        waitEdges(22);
        checkOutput("blank42", allHex(), 48'hFFFF_FFFF_99A4);
        applyStimulus(2'd0, 32'd0);
        waitEdges(22);
        checkOutput("blank0", allHex(), 48'hFFFF_FFFF_FFC0);
        applyStimulus(2'd0, 32'd1048575);
        waitEdges(22);
        checkOutput("sat_hex", allHex(), 48'h9090_9090_9090);
        readReg(2'd0, rd);
        checkOutput("sat_rd", {16'd0, rd}, 48'd999999);

        applyStimulus(2'd1, 32'd0);
        checkOutput("ctrl_reg_lag", allHex(), 48'h9090_9090_9090);
        waitEdges(1);
        checkOutput("disp_off", allHex(), 48'hFFFF_FFFF_FFFF);
        applyStimulus(2'd1, 32'd1);

        // 5, then 7 at E3 and 9 at E4: 7 is superseded and never shown
        applyStimulus(2'd0, 32'd5);
        repeat (2) @(posedge clk);
        applyStimulus(2'd0, 32'd7);
        applyStimulus(2'd0, 32'd9);
        readReg(2'd2, rd);
        checkOutput("pending_set", {16'd0, rd}, 48'd3);
        readReg(2'd0, rd);
        checkOutput("score_latest", {16'd0, rd}, 48'd9);
        saw7 = 1'b0;
        for (int k = 5; k <= 44; k++) begin
            @(posedge clk);
            #1;
            if (hex0 == 8'hF8) saw7 = 1'b1;
            if (k == 22) checkOutput("first_conv", allHex(), 48'hC0C0_C0C0_C092);
        end
        checkOutput("second_conv", allHex(), 48'hC0C0_C0C0_C090);
        checkOutput("never7", {47'd0, saw7}, 48'd0);
        readReg(2'd2, rd);
        checkOutput("pending_clr", {16'd0, rd}, 48'd0);

        applyStimulus(2'd0, 32'd999);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_hex", allHex(), 48'hFFFF_FFFF_FFFF);
        readReg(2'd2, rd);
        checkOutput("abort_status", {16'd0, rd}, 48'd0);
        readReg(2'd0, rd);
        checkOutput("abort_score", {16'd0, rd}, 48'd0);
        @(negedge clk);
        reset_n = 1'b1;
        waitEdges(25);
        checkOutput("after_abort", allHex(), 48'hFFFF_FFFF_FFFF);

`ifdef HEX_SCOREBOARD_BLINK_EN
        applyStimulus(2'd3, 32'd4);
        readReg(2'd3, rd);
        checkOutput("period_rd", {16'd0, rd}, 48'd4);
        applyStimulus(2'd1, 32'd5);
        waitEdges(1);
        checkOutput("blink_on0", allHex(), 48'hC0C0_C0C0_C0C0);
        waitEdges(4);
        checkOutput("blink_off0", allHex(), 48'hFFFF_FFFF_FFFF);
        waitEdges(3);
        checkOutput("blink_off1", allHex(), 48'hFFFF_FFFF_FFFF);
        waitEdges(1);
        checkOutput("blink_on1", allHex(), 48'hC0C0_C0C0_C0C0);
        applyStimulus(2'd3, 32'd0);
        waitEdges(2);
        unsteady = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (allHex() !== 48'hC0C0_C0C0_C0C0) unsteady = 1'b1;
            waitEdges(1);
        end
        checkOutput("period0_steady", {47'd0, unsteady}, 48'd0);
`else
        applyStimulus(2'd1, 32'd7);
        readReg(2'd1, rd);
        checkOutput("ctrl_mask", {16'd0, rd}, 48'd3);
        applyStimulus(2'd3, 32'h1234);
        readReg(2'd3, rd);
        checkOutput("period_absent", {16'd0, rd}, 48'd0);
        unsteady = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (allHex() !== 48'hFFFF_FFFF_FFC0) unsteady = 1'b1;
            waitEdges(1);
        end
        checkOutput("no_blink", {47'd0, unsteady}, 48'd0);
`endif
        applyStimulus(2'd2, 32'd3);
        readReg(2'd2, rd);
        checkOutput("status_ro", {16'd0, rd}, 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
